// File: rtl/acq_readout_sequencer.sv
// Readout sequencer for the double-banked acquisition memory: queues bank readout
// requests and serialises each frame MSB-first (timestamp header, then bank words).
module acq_readout_sequencer #(
    parameter int TS_W   = 30,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank_full,
    input  logic              acq_done,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic [TS_W-1:0]   timestamp,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sdo,
    output logic              sdo_valid,
    input  logic              sdo_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy,
    output logic              overflow
);

    localparam int SH_W  = (TS_W > DATA_W) ? TS_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_TS    = 3'd1,
        SHIFT_TS   = 3'd2,
        RD_REQ     = 3'd3,
        RD_WAIT    = 3'd4,
        SHIFT_DATA = 3'd5
    } state_t;

    state_t             state_r, state_nx_s;
    logic [SH_W-1:0]    shreg_r, shreg_nx_s;
    logic [CNT_W-1:0]   bitcnt_r, bitcnt_nx_s;
    logic [ADDR_W-1:0]  idx_r, idx_nx_s;

    logic               q_bank_r  [2];
    logic [ADDR_W-1:0]  q_end_r   [2];
    logic               q_first_r [2];
    logic               q_last_r  [2];
    logic               rd_ptr_r, wr_ptr_r;
    logic [1:0]         count_r, count_nx_s;
    logic               wr_bank_r, in_acq_r, overflow_r;

    logic               head_bank_s, head_first_s, head_last_s;
    logic [ADDR_W-1:0]  head_end_s;
    logic               push_s, accept_s, pop_s;
    logic [ADDR_W-1:0]  done_idx_s, push_end_s;
    logic               rd_en_s, sdo_valid_s, frame_start_s, frame_end_s;
    logic [ADDR_W:0]    rd_addr_s;

    assign head_bank_s  = q_bank_r[rd_ptr_r];
    assign head_end_s   = q_end_r[rd_ptr_r];
    assign head_first_s = q_first_r[rd_ptr_r];
    assign head_last_s  = q_last_r[rd_ptr_r];

    // Request decode: a coincident bank_full/acq_done becomes one full, final entry
    always_comb begin
        push_s     = bank_full | acq_done;
        done_idx_s = (last_idx > LAST_WORD) ? LAST_WORD : last_idx;
        if (bank_full) begin
            push_end_s = LAST_WORD;
        end else begin
            push_end_s = done_idx_s;
        end
        accept_s   = push_s && ((count_r != 2'd2) || pop_s);
        count_nx_s = count_r + {1'b0, accept_s} - {1'b0, pop_s};
    end

    // Request queue, bank tracking and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                q_bank_r[i]  <= 1'b0;
                q_end_r[i]   <= '0;
                q_first_r[i] <= 1'b0;
                q_last_r[i]  <= 1'b0;
            end
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            wr_bank_r  <= 1'b0;
            in_acq_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                q_bank_r[wr_ptr_r]  <= wr_bank_r;
                q_end_r[wr_ptr_r]   <= push_end_s;
                q_first_r[wr_ptr_r] <= ~in_acq_r;
                q_last_r[wr_ptr_r]  <= acq_done;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nx_s;
            if (push_s) begin
                wr_bank_r <= ~wr_bank_r;
                in_acq_r  <= ~acq_done;
                if (!accept_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    // Sequencer next-state, datapath and output decode
    always_comb begin
        state_nx_s    = state_r;
        shreg_nx_s    = shreg_r;
        bitcnt_nx_s   = bitcnt_r;
        idx_nx_s      = idx_r;
        rd_en_s       = 1'b0;
        rd_addr_s     = '0;
        sdo_valid_s   = 1'b0;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                idx_nx_s = '0;
                if (count_r != 2'd0) begin
                    state_nx_s = head_first_s ? LOAD_TS : RD_REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LOAD_TS: begin
                shreg_nx_s    = SH_W'(timestamp) << (SH_W - TS_W);
                bitcnt_nx_s   = CNT_W'(TS_W - 1);
                frame_start_s = 1'b1;
                state_nx_s    = SHIFT_TS;
            end
            SHIFT_TS: begin
                sdo_valid_s = 1'b1;
                if (sdo_ready) begin
                    shreg_nx_s = shreg_r << 1;
                    if (bitcnt_r == '0) begin
                        state_nx_s = RD_REQ;
                    end else begin
                        bitcnt_nx_s = bitcnt_r - CNT_W'(1);
                    end
                end else begin
                    state_nx_s = SHIFT_TS;
                end
            end
            RD_REQ: begin
                rd_en_s    = 1'b1;
                rd_addr_s  = {head_bank_s, idx_r};
                state_nx_s = RD_WAIT;
            end
            RD_WAIT: begin
                shreg_nx_s  = SH_W'(rd_data) << (SH_W - DATA_W);
                bitcnt_nx_s = CNT_W'(DATA_W - 1);
                state_nx_s  = SHIFT_DATA;
            end
            SHIFT_DATA: begin
                sdo_valid_s = 1'b1;
                if (sdo_ready) begin
                    shreg_nx_s = shreg_r << 1;
                    if (bitcnt_r != '0) begin
                        bitcnt_nx_s = bitcnt_r - CNT_W'(1);
                    end else if (idx_r == head_end_s) begin
                        pop_s       = 1'b1;
                        frame_end_s = head_last_s;
                        state_nx_s  = IDLE;
                    end else begin
                        idx_nx_s   = idx_r + ADDR_W'(1);
                        state_nx_s = RD_REQ;
                    end
                end else begin
                    state_nx_s = SHIFT_DATA;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shreg_r  <= '0;
            bitcnt_r <= '0;
            idx_r    <= '0;
        end else begin
            state_r  <= state_nx_s;
            shreg_r  <= shreg_nx_s;
            bitcnt_r <= bitcnt_nx_s;
            idx_r    <= idx_nx_s;
        end
    end

    assign rd_en       = rd_en_s;
    assign rd_addr     = rd_addr_s;
    assign sdo_valid   = sdo_valid_s;
    assign sdo         = sdo_valid_s & shreg_r[SH_W-1];
    assign frame_start = frame_start_s;
    assign frame_end   = frame_end_s;
    assign busy        = (state_r != IDLE) || (count_r != 2'd0);
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Scoreboard bench for acq_readout_sequencer (TS_W=8, DATA_W=4, DEPTH=4, ADDR_W=2).
module tb_acq_readout_sequencer;

    logic       clk, reset;
    logic       bank_full, acq_done;
    logic [1:0] last_idx;
    logic [7:0] timestamp;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic       sdo, sdo_valid, sdo_ready;
    logic       frame_start, frame_end, busy, overflow;

    acq_readout_sequencer #(.TS_W(8), .DATA_W(4), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .bank_full(bank_full), .acq_done(acq_done),
        .last_idx(last_idx), .timestamp(timestamp), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .sdo(sdo), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy), .overflow(overflow)
    );

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] addr_q[$];
    logic [3:0] mem [0:7];
    int         errors = 0, checks = 0;
    int         fs_count = 0, fe_count = 0, hs_count = 0;
    logic       m_bank, m_in_acq;
    logic       ready_level = 1'b1;
    logic       toggle_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        sdo_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            sdo_ready = toggle_en ? ~sdo_ready : ready_level;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted bit and every read
    initial begin
        logic held_v, held_sdo;
        exp_t e;
        held_v = 1'b0;
        held_sdo = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (frame_start) fs_count++;
                if (frame_end) fe_count++;
                if (held_v && sdo_valid) check("stall_stable", sdo, held_sdo);
                held_v = sdo_valid && !sdo_ready;
                held_sdo = sdo;
                if (sdo_valid && sdo_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("extra_bit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sdo", sdo, e.b);
                        check("frame_end", frame_end, e.last);
                    end
                end else if (frame_end) begin
                    check("frame_end_nohs", 1, 0);
                end
                if (rd_en) begin
                    if (addr_q.size() == 0) check("extra_rd", 1, 0);
                    else check("rd_addr", rd_addr, addr_q.pop_front());
                end
            end
        end
    end

    task automatic model_push(input bit full, input bit done, input logic [1:0] lidx, input bit drop);
        int end_i;
        logic [2:0] a;
        logic [3:0] w;
        end_i = full ? 3 : int'(lidx);
        if (!drop) begin
            if (!m_in_acq) begin
                for (int b = 7; b >= 0; b--) exp_q.push_back('{timestamp[b], 1'b0});
            end
            for (int i = 0; i <= end_i; i++) begin
                a = {m_bank, 2'(i)};
                w = mem[a];
                addr_q.push_back(a);
                for (int b = 3; b >= 0; b--)
                    exp_q.push_back('{w[b], logic'(done && (i == end_i) && (b == 0))});
            end
        end
        m_in_acq = ~done;
        m_bank = ~m_bank;
    endtask

    task automatic req(input bit full, input bit done, input logic [1:0] lidx, input bit drop);
        @(posedge clk);
        #1;
        bank_full = full;
        acq_done = done;
        last_idx = lidx;
        model_push(full, done, lidx, drop);
        @(posedge clk);
        #1;
        bank_full = 1'b0;
        acq_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bank_full = 1'b0;
        acq_done = 1'b0;
        last_idx = 2'd0;
        toggle_en = 1'b0;
        ready_level = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {rd_en, rd_addr, sdo, sdo_valid, frame_start, frame_end, busy, overflow}, 0);
        exp_q.delete();
        addr_q.delete();
        m_bank = 1'b0;
        m_in_acq = 1'b0;
        reset = 1'b0;
        fs_count = 0;
        fe_count = 0;
        hs_count = 0;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        check("drain_done", (exp_q.size() == 0) && (addr_q.size() == 0) && !busy, 1);
    endtask

    initial begin
        mem = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h6, 4'h9, 4'hF, 4'h1};
        rd_data = 4'h0;
        timestamp = 8'h00;
        do_reset();

        // Partial final bank with header latency
        timestamp = 8'hA5;
        req(1'b0, 1'b1, 2'd1, 1'b0);
        check("lat_c0_valid", sdo_valid, 0);
        check("lat_c0_busy", busy, 1);
        @(posedge clk); #1;
        check("lat_c1_fstart", frame_start, 1);
        @(posedge clk); #1;
        check("lat_c2_valid", sdo_valid, 1);
        drain(200);
        check("t2_bits", hs_count, 16);
        check("t2_fstart", fs_count, 1);
        check("t2_fend", fe_count, 1);

        // Full bank then one-word final bank
        do_reset();
        timestamp = 8'h3C;
        req(1'b1, 1'b0, 2'd0, 1'b0);
        req(1'b0, 1'b1, 2'd0, 1'b0);
        drain(400);
        check("t3_bits", hs_count, 28);
        check("t3_fstart", fs_count, 1);
        check("t3_fend", fe_count, 1);

        // Same stream with sdo_ready toggling every cycle
        do_reset();
        timestamp = 8'h96;
        toggle_en = 1'b1;
        req(1'b1, 1'b0, 2'd0, 1'b0);
        req(1'b0, 1'b1, 2'd0, 1'b0);
        drain(800);
        toggle_en = 1'b0;
        check("t4_bits", hs_count, 28);
        check("t4_fend", fe_count, 1);

        // Coincident bank_full and acq_done
        do_reset();
        timestamp = 8'h5A;
        req(1'b1, 1'b1, 2'd2, 1'b0);
        drain(400);
        check("t5_bits", hs_count, 24);
        check("t5_fstart", fs_count, 1);
        check("t5_fend", fe_count, 1);

        // Overflow: third push lands in a full queue while the sink stalls
        do_reset();
        timestamp = 8'hC3;
        ready_level = 1'b0;
        req(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 20 && !sdo_valid; i++) begin
            @(posedge clk); #1;
        end
        check("t6_streaming", sdo_valid, 1);
        req(1'b0, 1'b1, 2'd1, 1'b0);
        check("t6_no_ovf_yet", overflow, 0);
        req(1'b1, 1'b0, 2'd0, 1'b1);
        check("t6_overflow", overflow, 1);
        ready_level = 1'b1;
        drain(400);
        repeat (10) @(posedge clk);
        #1;
        check("t6_bits", hs_count, 32);
        check("t6_sticky", overflow, 1);
        check("t6_idle", busy, 0);
        check("t6_fend", fe_count, 1);

        // Reset in the middle of the header
        do_reset();
        timestamp = 8'h99;
        req(1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 40 && hs_count < 3; i++) begin
            @(posedge clk); #1;
        end
        check("t7_mid_header", hs_count, 3);
        reset = 1'b1;
        #1;
        check("t7_abort_outs", {rd_en, rd_addr, sdo, sdo_valid, frame_start, frame_end, busy, overflow}, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t7_idle", {busy, sdo_valid}, 0);
        check("t7_no_fend", fe_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
